// File: rtl/store_issue_buffer.sv
// store_issue_buffer: in-order queue between the issue stage and the store unit.
// Each request is decoded when it is written: the byte-enable mask and the
// misalignment flag are computed then, so the store unit sees a complete head entry.
//
// Handshake: a push happens on a clock edge where valid_i && ready_o.
// A pop happens on a clock edge where pop_i && valid_o.
// ready_o depends only on the registered count. It does not look at pop_i.
// flush_i takes priority over both the push and the pop in the same cycle.
module store_issue_buffer #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [VLEN-1:0]          vaddr_i,
    input  logic [XLEN-1:0]          data_i,
    input  logic [1:0]               size_i,
    input  logic                     is_amo_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     pop_i,
    output logic [VLEN-1:0]          vaddr_o,
    output logic [XLEN-1:0]          data_o,
    output logic [1:0]               size_o,
    output logic                     is_amo_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN/8-1:0]        be_o,
    output logic                     misaligned_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BE_W  = XLEN / 8;

    // Entry storage
    logic [VLEN-1:0]          r_vaddr    [DEPTH];
    logic [XLEN-1:0]          r_data     [DEPTH];
    logic [1:0]               r_size     [DEPTH];
    logic                     r_is_amo   [DEPTH];
    logic [TRANS_ID_BITS-1:0] r_trans_id [DEPTH];
    logic [BE_W-1:0]          r_be       [DEPTH];
    logic                     r_mis      [DEPTH];

    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;

    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_off;
    logic [7:0]      w_be_full;
    logic [BE_W-1:0] w_be;
    logic            w_mis;

    assign ready_o = (r_count != CNT_W'(DEPTH));
    assign valid_o = (r_count != '0);
    assign empty_o = (r_count == '0);

    // The push and pop enables are masked while a flush is active.
    assign w_push = valid_i && ready_o && !flush_i;
    assign w_pop  = pop_i && valid_o && !flush_i;

    // Decode the incoming request into a byte-enable mask and a misalignment flag.
    // The mask is built 8 bits wide and then truncated to the bus byte count.
    always_comb begin
        w_off     = 3'd0;
        w_be_full = 8'h00;
        w_mis     = 1'b0;
        if (XLEN == 64) begin
            w_off = vaddr_i[2:0];
        end else begin
            w_off = {1'b0, vaddr_i[1:0]};
        end
        case (size_i)
            2'd0: begin
                w_be_full = 8'h01 << w_off;
                w_mis     = 1'b0;
            end
            2'd1: begin
                w_be_full = 8'h03 << w_off;
                w_mis     = vaddr_i[0];
            end
            2'd2: begin
                w_be_full = 8'h0F << w_off;
                w_mis     = (vaddr_i[1:0] != 2'b00);
            end
            default: begin
                w_be_full = 8'hFF;
                // A doubleword access is never legal on a 32-bit bus.
                w_mis     = (vaddr_i[2:0] != 3'b000) || (XLEN == 32);
            end
        endcase
        w_be = w_be_full[BE_W-1:0];
    end

    // Write the decoded request into the slot at the write pointer.
    // Storage is cleared on reset so that the head fields read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vaddr[i]    <= '0;
                r_data[i]     <= '0;
                r_size[i]     <= '0;
                r_is_amo[i]   <= 1'b0;
                r_trans_id[i] <= '0;
                r_be[i]       <= '0;
                r_mis[i]      <= 1'b0;
            end
        end else if (w_push) begin
            r_vaddr[r_wptr]    <= vaddr_i;
            r_data[r_wptr]     <= data_i;
            r_size[r_wptr]     <= size_i;
            r_is_amo[r_wptr]   <= is_amo_i;
            r_trans_id[r_wptr] <= trans_id_i;
            r_be[r_wptr]       <= w_be;
            r_mis[r_wptr]      <= w_mis;
        end
    end

    // Update the pointers and the count. DEPTH is a power of two, so pointer
    // overflow wraps naturally. A flush returns the queue to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The head fields are driven combinationally from the slot at the read pointer.
    assign vaddr_o      = r_vaddr[r_rptr];
    assign data_o       = r_data[r_rptr];
    assign size_o       = r_size[r_rptr];
    assign is_amo_o     = r_is_amo[r_rptr];
    assign trans_id_o   = r_trans_id[r_rptr];
    assign be_o         = r_be[r_rptr];
    assign misaligned_o = r_mis[r_rptr];

endmodule

// File: tb/tb_store_issue_buffer.sv
// Bench for store_issue_buffer using the default parameters (DEPTH=2, XLEN=64).
// The reference model is a queue of expected entries. Each entry's byte enables
// and misalignment flag are derived from the access size by plain arithmetic.
module tb_store_issue_buffer;

    localparam int DEPTH = 2;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [38:0] vaddr_i;
    logic [63:0] data_i;
    logic [1:0]  size_i;
    logic        is_amo_i;
    logic [2:0]  trans_id_i;
    logic        valid_o;
    logic        pop_i;
    logic [38:0] vaddr_o;
    logic [63:0] data_o;
    logic [1:0]  size_o;
    logic        is_amo_o;
    logic [2:0]  trans_id_o;
    logic [7:0]  be_o;
    logic        misaligned_o;
    logic        empty_o;

    store_issue_buffer #(.DEPTH(2), .XLEN(64), .VLEN(39), .TRANS_ID_BITS(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .vaddr_i(vaddr_i),
        .data_i(data_i), .size_i(size_i), .is_amo_i(is_amo_i),
        .trans_id_i(trans_id_i), .valid_o(valid_o), .pop_i(pop_i),
        .vaddr_o(vaddr_o), .data_o(data_o), .size_o(size_o),
        .is_amo_o(is_amo_o), .trans_id_o(trans_id_o), .be_o(be_o),
        .misaligned_o(misaligned_o), .empty_o(empty_o)
    );

    typedef struct {
        logic [38:0] vaddr;
        logic [63:0] data;
        logic [1:0]  size;
        logic        amo;
        logic [2:0]  id;
        logic [7:0]  be;
        logic        mis;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // An access of 2^size bytes starting at byte offset (addr mod 8).
    // A doubleword covers the whole bus.
    function automatic logic [7:0] m_be(input logic [38:0] a, input logic [1:0] s);
        int          nb;
        int          off;
        logic [63:0] m;
        nb  = 1 << s;
        off = int'(a[2:0]);
        if (s == 2'd3) return 8'hFF;
        m = ((64'd1 << nb) - 64'd1) << off;
        return m[7:0];
    endfunction

    // An access is misaligned when its address is not a multiple of its size.
    function automatic logic m_mis(input logic [38:0] a, input logic [1:0] s);
        int nb;
        nb = 1 << s;
        return (int'(a[5:0]) % nb) != 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [38:0] a, input logic [1:0] s,
                          input logic [2:0] id, input logic p, input logic f);
        valid_i    = v;
        vaddr_i    = a;
        size_i     = s;
        trans_id_i = id;
        pop_i      = p;
        flush_i    = f;
        data_i     = {$urandom, $urandom};
        is_amo_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_head();
        chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
        chk("empty_o", {63'd0, empty_o}, {63'd0, q.size() == 0});
        chk("ready_o", {63'd0, ready_o}, {63'd0, q.size() != DEPTH});
        if (q.size() != 0) begin
            chk("vaddr_o", {25'd0, vaddr_o}, {25'd0, q[0].vaddr});
            chk("data_o", data_o, q[0].data);
            chk("size_o", {62'd0, size_o}, {62'd0, q[0].size});
            chk("is_amo_o", {63'd0, is_amo_o}, {63'd0, q[0].amo});
            chk("trans_id_o", {61'd0, trans_id_o}, {61'd0, q[0].id});
            chk("be_o", {56'd0, be_o}, {56'd0, q[0].be});
            chk("misaligned_o", {63'd0, misaligned_o}, {63'd0, q[0].mis});
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_empty", {63'd0, empty_o}, 64'd1);
        chk("rst_vaddr", {25'd0, vaddr_o}, 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_be", {56'd0, be_o}, 64'd0);
        chk("rst_size", {62'd0, size_o}, 64'd0);
        chk("rst_amo", {63'd0, is_amo_o}, 64'd0);
        chk("rst_id", {61'd0, trans_id_o}, 64'd0);
        chk("rst_mis", {63'd0, misaligned_o}, 64'd0);
    endtask

    // One clock cycle: predict the push and pop, advance the model at the edge,
    // then check the head outputs one time unit later.
    task automatic step();
        bit   m_push;
        bit   m_pop;
        ent_t e;
        chk("ready_pre", {63'd0, ready_o}, {63'd0, q.size() != DEPTH});
        m_push  = valid_i && (q.size() < DEPTH) && !flush_i;
        m_pop   = pop_i && (q.size() > 0) && !flush_i;
        e.vaddr = vaddr_i;
        e.data  = data_i;
        e.size  = size_i;
        e.amo   = is_amo_i;
        e.id    = trans_id_i;
        e.be    = m_be(vaddr_i, size_i);
        e.mis   = m_mis(vaddr_i, size_i);
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(e);
        end
        #1;
        check_head();
    endtask

    initial begin
        logic [38:0] ra;
        rst_ni = 1'b0;
        set_in(0, 39'd0, 2'd0, 3'd0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_vals();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Byte enables for aligned accesses of each size
        set_in(1, 39'h1003, 2'd0, 3'd1, 0, 0); step();
        chk("be_byte", {56'd0, be_o}, 64'h08);
        chk("mis_byte", {63'd0, misaligned_o}, 64'd0);
        set_in(1, 39'h1006, 2'd1, 3'd2, 1, 0); step();
        chk("be_half", {56'd0, be_o}, 64'hC0);
        chk("mis_half", {63'd0, misaligned_o}, 64'd0);
        set_in(1, 39'h1004, 2'd2, 3'd3, 1, 0); step();
        chk("be_word", {56'd0, be_o}, 64'hF0);
        chk("mis_word", {63'd0, misaligned_o}, 64'd0);
        set_in(1, 39'h1000, 2'd3, 3'd4, 1, 0); step();
        chk("be_dword", {56'd0, be_o}, 64'hFF);
        chk("mis_dword", {63'd0, misaligned_o}, 64'd0);
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();

        // Misaligned accesses are still buffered and presented
        set_in(1, 39'h2002, 2'd2, 3'd3, 0, 0); step();
        chk("be_mis_word", {56'd0, be_o}, 64'h3C);
        chk("mis_word_set", {63'd0, misaligned_o}, 64'd1);
        set_in(1, 39'h2001, 2'd1, 3'd4, 1, 0); step();
        chk("be_mis_half", {56'd0, be_o}, 64'h06);
        chk("mis_half_set", {63'd0, misaligned_o}, 64'd1);
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();

        // Fill the buffer and apply backpressure
        set_in(1, 39'h3000, 2'd3, 3'd1, 0, 0); step();
        chk("fill_id1", {61'd0, trans_id_o}, 64'd1);
        set_in(1, 39'h3008, 2'd3, 3'd2, 0, 0); step();
        chk("full_ready", {63'd0, ready_o}, 64'd0);
        set_in(1, 39'h3010, 2'd3, 3'd3, 0, 0); step();
        chk("held_id1", {61'd0, trans_id_o}, 64'd1);
        set_in(1, 39'h3010, 2'd3, 3'd3, 1, 0); step();
        chk("after_pop_ready", {63'd0, ready_o}, 64'd1);
        chk("after_pop_id2", {61'd0, trans_id_o}, 64'd2);
        set_in(1, 39'h3010, 2'd3, 3'd3, 0, 0); step();
        chk("id3_taken", {63'd0, ready_o}, 64'd0);
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();
        chk("order_id3", {61'd0, trans_id_o}, 64'd3);
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();
        chk("drained", {63'd0, valid_o}, 64'd0);

        // Sustained stream with a push and a pop every cycle
        for (int i = 0; i < 12; i++) begin
            ra = 39'({$urandom, $urandom});
            set_in(1, ra, 2'($urandom_range(0, 3)), 3'(i), 1, 0);
            step();
            chk("stream_ready", {63'd0, ready_o}, 64'd1);
            chk("stream_id", {61'd0, trans_id_o}, 64'(i % 8));
        end
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();

        // A flush in the same cycle as a push discards everything
        set_in(1, 39'h4000, 2'd2, 3'd6, 0, 0); step();
        set_in(1, 39'h4004, 2'd2, 3'd7, 0, 0); step();
        set_in(1, 39'h4008, 2'd2, 3'd5, 0, 1); step();
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        chk("flush_empty", {63'd0, empty_o}, 64'd1);
        set_in(0, 39'd0, 2'd0, 3'd0, 0, 0); step();
        chk("flush_stays_empty", {63'd0, valid_o}, 64'd0);

        // A pop while empty is ignored
        set_in(0, 39'd0, 2'd0, 3'd0, 1, 0); step();
        set_in(1, 39'h5000, 2'd0, 3'd2, 0, 0); step();
        chk("after_empty_pop", {61'd0, trans_id_o}, 64'd2);
        chk("single_ready", {63'd0, ready_o}, 64'd1);

        // Asynchronous reset in the middle of a cycle
        set_in(0, 39'd0, 2'd0, 3'd0, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        q.delete();
        check_reset_vals();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ra = 39'({$urandom, $urandom});
            set_in(1'($urandom_range(0, 3) != 0), ra, 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                   1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_issue_buffer.md
# store_issue_buffer

Buffers store and AMO requests issued by the issue stage and presents them in order to the store unit's `valid_i`/`lsu_ctrl_i` inputs. Each request is released only when the store unit pops it. On entry, the buffer generates the byte-enable mask and the misalignment flag, so the store unit receives a fully decoded request. Flush discards all buffered requests.

## Interface
- `DEPTH`, 2: number of entries; power of two, at least 2.
- `XLEN`, 64: data width; 32 or 64.
- `VLEN`, 39: virtual address width.
- `TRANS_ID_BITS`, 3: transaction ID width.

Ports (clock and reset first):
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all entries.
- `valid_i` in 1: issue request valid.
- `ready_o` out 1: buffer can accept a request.
- `vaddr_i` in VLEN: store virtual address.
- `data_i` in XLEN: store data, unaligned (LSB-justified).
- `size_i` in 2: access size; 0=byte, 1=half, 2=word, 3=dword.
- `is_amo_i` in 1: request is an AMO.
- `trans_id_i` in TRANS_ID_BITS: scoreboard ID.
- `valid_o` out 1: head entry valid.
- `pop_i` in 1: store unit consumes the head entry.
- `vaddr_o`, `data_o`, `size_o`, `is_amo_o`, `trans_id_o` out: head entry fields.
- `be_o` out XLEN/8: head byte enable.
- `misaligned_o` out 1: head access is misaligned.
- `empty_o` out 1: no entries held.

## Operation
- **Storage.** Circular FIFO with read pointer, write pointer and count. Pointer width is log2(DEPTH); pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- **Push.** A push occurs when `valid_i && ready_o`. The entry stores all input fields plus the computed `be` and `misaligned`.
- **Ready.** `ready_o = (count != DEPTH)`. It is not combinationally dependent on `pop_i`, so a full buffer does not accept a push in the same cycle as a pop.
- **Pop.** A pop occurs when `pop_i && valid_o`. A pop while empty is ignored; count and pointers are unchanged.
- **Head outputs.** `valid_o = (count != 0)` and `empty_o = (count == 0)`. The head fields are driven combinationally from the entry at the read pointer.
- **Byte offset.** `off = vaddr_i[2:0]` when XLEN=64, and `{1'b0, vaddr_i[1:0]}` when XLEN=32.
- **Byte-enable generation.**
  - size 0: `1 << off`
  - size 1: `2'b11 << off`
  - size 2: `4'hF << off`
  - size 3: all ones
  - The result is truncated to XLEN/8 bits.
- **Misalignment.**
  - size 1 with `vaddr_i[0]` set.
  - size 2 with `vaddr_i[1:0] != 0`.
  - size 3 with `vaddr_i[2:0] != 0`.
  - size 3 when XLEN=32, always.
  - A misaligned entry is still buffered and presented. The store unit or exception path raises the fault.
- **Flush.** `flush_i` sets count and both pointers to 0 at the next edge. A push or pop in the same cycle has no effect. The entry storage need not be cleared.
- **Simultaneous push and pop.** When not full, both occur and the count is unchanged. When empty, the pop is ignored and only the push occurs.

## Timing
- **Latency.** A request pushed at edge N appears on `valid_o` after edge N. Minimum issue-to-store-unit latency is one cycle; there is no fall-through.
- **Throughput.** One push and one pop per cycle. Sustained one request per cycle when the store unit pops every cycle.
- **Reset values.**
  - `valid_o=0`, `ready_o=1`, `empty_o=1`.
  - Pointers and count are 0.
  - All entry storage is reset to 0, so `vaddr_o`, `data_o`, `be_o`, `size_o`, `is_amo_o`, `trans_id_o` and `misaligned_o` read 0.
- **Reset mid-operation.** Asserting `rst_ni` low returns the block to the reset state immediately (asynchronously), regardless of count.
- **Head stability.** The head outputs are stable while `valid_o && !pop_i`. They change only on a pop, a flush, or a push into an empty buffer.

## Test plan
- **Byte enables (XLEN=64).** Push vaddr=0x1003 size0, then 0x1006 size1, then 0x1004 size2, then 0x1000 size3 → `be_o` = 0x08, 0xC0, 0xF0, 0xFF in order, each with `misaligned_o=0`.
- **Misalignment.** Push vaddr=0x2002 size2, then 0x2001 size1 → `misaligned_o=1` for both, `be_o` = 0x3C and 0x06.
- **Fill and backpressure (DEPTH=2).** Push trans_id 1 and 2 back-to-back with `pop_i=0` → `ready_o=0` after the second edge. A third request held on `valid_i` is not accepted. Pop once → `ready_o=1` the following cycle and trans_id 3 is accepted. Output order is 1, 2, 3.
- **Sustained stream.** Issue valid every cycle with pop every cycle → one entry per cycle, count never exceeds 1, `ready_o` stays 1, IDs emerge in order.
- **Flush.** With 2 entries held, assert `flush_i` together with `valid_i` (trans_id 5) → the next cycle shows `valid_o=0`, `empty_o=1`, and trans_id 5 is never presented.
- **Empty pop and reset.** Assert `pop_i` while empty → count stays 0. With 1 entry held, pulse `rst_ni` low mid-cycle → `valid_o=0` and `ready_o=1` immediately.
